psram_resp: RTL

//  Synthesizable OPI DDR PSRAM responder: the memory-side end of psram_if (tb modport).

---
 rtl/psram_resp_pkg.sv | 31 +++
 rtl/psram_resp_if.sv | 25 ++
 rtl/psram_resp_mem.sv | 27 ++
 rtl/psram_resp.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/psram_resp_pkg.sv
// Shared types and defaults for the OPI DDR PSRAM responder.
// The optional write data mask is enabled by defining PSRAM_RESP_DM_EN.
package psram_resp_pkg;

  localparam int unsigned DEF_DEPTH  = 32'd1024;
  localparam logic [7:0]  DEF_RD_CMD = 8'h20;
  localparam logic [7:0]  DEF_WR_CMD = 8'hA0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    WAIT   = 3'd3,
    RDATA  = 3'd4,
    WDATA  = 3'd5,
    IGNORE = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2
  } edge_t;

  function automatic logic op_known(input logic [7:0] op,
                                    input logic [7:0] rd_cmd,
                                    input logic [7:0] wr_cmd);
    return (op == rd_cmd) || (op == wr_cmd);
  endfunction

endpackage

// File: rtl/psram_resp_if.sv
// OPI PSRAM pin bundle; names follow the controller's point of view.
interface psram_resp_if;

  logic       psram_sck_o;
  logic       psram_ce_o;
  logic [7:0] psram_io_en_o;
  logic [7:0] psram_io_out_o;
  logic       psram_dqs_en_o;
  logic       psram_dqs_out_o;
  logic [7:0] psram_io_in_i;
  logic       psram_dqs_in_i;

  modport master (
    output psram_sck_o, psram_ce_o, psram_io_en_o, psram_io_out_o,
           psram_dqs_en_o, psram_dqs_out_o,
    input  psram_io_in_i, psram_dqs_in_i
  );

  modport slave (
    input  psram_sck_o, psram_ce_o, psram_io_en_o, psram_io_out_o,
           psram_dqs_en_o, psram_dqs_out_o,
    output psram_io_in_i, psram_dqs_in_i
  );

endinterface

// File: rtl/psram_resp_mem.sv
// Byte RAM behind the PSRAM responder: synchronous write, combinational read.
module psram_resp_mem
  import psram_resp_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned AW    = 10
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_r [DEPTH];

  // Write port; contents are intentionally not reset
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_r[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_r[raddr_i];

endmodule

// File: rtl/psram_resp.sv
// OPI DDR PSRAM responder: decodes oversampled SCK/CE/IO, serves burst reads/writes.
// Define PSRAM_RESP_DM_EN to honour the controller's DQS write mask in WDATA.
module psram_resp
  import psram_resp_pkg::*;
#(
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter logic [7:0]  RD_CMD = DEF_RD_CMD,
  parameter logic [7:0]  WR_CMD = DEF_WR_CMD
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  psram_resp_if.slave      bus,
  input  logic [7:0]       lat_i,
  output logic             busy_o,
  output logic             err_o
);

  localparam int unsigned   AW      = (DEPTH > 32'd1) ? $clog2(DEPTH) : 32'd1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);
  localparam logic [AW-1:0] PTR_ZERO = AW'(1'b0);

  logic          sck_m_r, sck_q_r, sck_qq_r;
  logic          ce_m_r, ce_q_r, ce_qq_r;
  logic [7:0]    io_m_r, io_q_r, io_en_m_r, io_en_q_r;
  logic          mask_s;

  state_t        state_r, state_nx;
  edge_t         edge_s;
  logic          any_edge_s, ce_rise_s, ce_fall_s, op_ok_s, is_rd_s;

  logic [AW-1:0] ptr_r, ptr_s, ptr_sh_s;
  logic [1:0]    addr_cnt_r, addr_cnt_s;
  logic [7:0]    wait_cnt_r, wait_cnt_s;
  logic [7:0]    opcode_r, opcode_s;
  logic [7:0]    io_in_r, io_in_s;
  logic          dqs_in_r, dqs_in_s, busy_r, busy_s, err_r, err_s;
  logic          mem_we_s;
  logic [7:0]    mem_rdata_s;

  // Two-stage synchronizer; sck and ce get one more stage for edge detection
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sck_m_r   <= 1'b0;
      sck_q_r   <= 1'b0;
      sck_qq_r  <= 1'b0;
      ce_m_r    <= 1'b1;
      ce_q_r    <= 1'b1;
      ce_qq_r   <= 1'b1;
      io_m_r    <= 8'h00;
      io_q_r    <= 8'h00;
      io_en_m_r <= 8'h00;
      io_en_q_r <= 8'h00;
    end else begin
      sck_m_r   <= bus.psram_sck_o;
      sck_q_r   <= sck_m_r;
      sck_qq_r  <= sck_q_r;
      ce_m_r    <= bus.psram_ce_o;
      ce_q_r    <= ce_m_r;
      ce_qq_r   <= ce_q_r;
      io_m_r    <= bus.psram_io_out_o;
      io_q_r    <= io_m_r;
      io_en_m_r <= bus.psram_io_en_o;
      io_en_q_r <= io_en_m_r;
    end
  end

`ifdef PSRAM_RESP_DM_EN
  logic dqs_en_m_r, dqs_en_q_r, dqs_out_m_r, dqs_out_q_r;

  // Write mask travels through the same pipeline as the data it qualifies
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dqs_en_m_r  <= 1'b0;
      dqs_en_q_r  <= 1'b0;
      dqs_out_m_r <= 1'b0;
      dqs_out_q_r <= 1'b0;
    end else begin
      dqs_en_m_r  <= bus.psram_dqs_en_o;
      dqs_en_q_r  <= dqs_en_m_r;
      dqs_out_m_r <= bus.psram_dqs_out_o;
      dqs_out_q_r <= dqs_out_m_r;
    end
  end

  assign mask_s = dqs_en_q_r & dqs_out_q_r;
`else
  assign mask_s = 1'b0;
`endif

  assign ce_rise_s  = ce_q_r & ~ce_qq_r;
  assign ce_fall_s  = ~ce_q_r & ce_qq_r;
  assign any_edge_s = (edge_s != EDGE_NONE);
  assign op_ok_s    = op_known(opcode_r, RD_CMD, WR_CMD);
  assign is_rd_s    = (opcode_r == RD_CMD);
  assign ptr_sh_s   = AW'({ptr_r, io_q_r});

  // Classify SCK transitions; only edges inside an active CE window count
  always_comb begin
    edge_s = EDGE_NONE;
    if (!ce_q_r && (sck_q_r != sck_qq_r)) begin
      if (sck_q_r) begin
        edge_s = EDGE_RISE;
      end else begin
        edge_s = EDGE_FALL;
      end
    end else begin
      edge_s = EDGE_NONE;
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state logic; CE deassertion overrides everything, including a coincident edge
  always_comb begin
    state_nx = state_r;
    if (ce_rise_s) begin
      state_nx = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (ce_fall_s) state_nx = CMD;
          else           state_nx = IDLE;
        end
        CMD: begin
          if (edge_s == EDGE_FALL) state_nx = op_ok_s ? ADDR : IGNORE;
          else                     state_nx = CMD;
        end
        ADDR: begin
          if (any_edge_s && (addr_cnt_r == 2'd3)) begin
            if (!is_rd_s)              state_nx = WDATA;
            else if (lat_i != 8'd0)    state_nx = WAIT;
            else                       state_nx = RDATA;
          end else begin
            state_nx = ADDR;
          end
        end
        WAIT: begin
          // leave on the fall closing the last latency cycle so data starts on a rise
          if ((edge_s == EDGE_FALL) && (wait_cnt_r == lat_i)) state_nx = RDATA;
          else                                                 state_nx = WAIT;
        end
        RDATA, WDATA, IGNORE: state_nx = state_r;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Output and datapath next values
  always_comb begin
    ptr_s      = ptr_r;
    addr_cnt_s = addr_cnt_r;
    wait_cnt_s = wait_cnt_r;
    opcode_s   = opcode_r;
    io_in_s    = 8'h00;
    dqs_in_s   = 1'b0;
    err_s      = 1'b0;
    mem_we_s   = 1'b0;
    busy_s     = (state_nx != IDLE);
    if (ce_rise_s) begin
      ptr_s      = PTR_ZERO;
      addr_cnt_s = 2'd0;
      wait_cnt_s = 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          ptr_s      = PTR_ZERO;
          addr_cnt_s = 2'd0;
          wait_cnt_s = 8'd0;
        end
        CMD: begin
          if (edge_s == EDGE_RISE)      opcode_s = io_q_r;
          else if (edge_s == EDGE_FALL) err_s    = ~op_ok_s;
          else                          opcode_s = opcode_r;
        end
        ADDR: begin
          if (any_edge_s) begin
            addr_cnt_s = addr_cnt_r + 2'd1;
            ptr_s      = (addr_cnt_r == 2'd3) ? (ptr_sh_s & ~PTR_ONE) : ptr_sh_s;
          end else begin
            ptr_s = ptr_r;
          end
        end
        WAIT: begin
          if (edge_s == EDGE_RISE) wait_cnt_s = wait_cnt_r + 8'd1;
          else                     wait_cnt_s = wait_cnt_r;
        end
        RDATA: begin
          if (any_edge_s) begin
            io_in_s  = mem_rdata_s;
            dqs_in_s = (edge_s == EDGE_RISE);
            ptr_s    = ptr_r + PTR_ONE;
            err_s    = (io_en_q_r != 8'h00);
          end else begin
            io_in_s  = io_in_r;
            dqs_in_s = dqs_in_r;
          end
        end
        WDATA: begin
          if (any_edge_s) begin
            mem_we_s = ~mask_s;
            ptr_s    = ptr_r + PTR_ONE;
          end else begin
            mem_we_s = 1'b0;
          end
        end
        IGNORE:  opcode_s = opcode_r;
        default: ptr_s = PTR_ZERO;
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_r      <= PTR_ZERO;
      addr_cnt_r <= 2'd0;
      wait_cnt_r <= 8'd0;
      opcode_r   <= 8'h00;
      io_in_r    <= 8'h00;
      dqs_in_r   <= 1'b0;
      busy_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      ptr_r      <= ptr_s;
      addr_cnt_r <= addr_cnt_s;
      wait_cnt_r <= wait_cnt_s;
      opcode_r   <= opcode_s;
      io_in_r    <= io_in_s;
      dqs_in_r   <= dqs_in_s;
      busy_r     <= busy_s;
      err_r      <= err_s;
    end
  end

  psram_resp_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (mem_we_s),
    .waddr_i (ptr_r),
    .wdata_i (io_q_r),
    .raddr_i (ptr_r),
    .rdata_o (mem_rdata_s)
  );

  assign bus.psram_io_in_i  = io_in_r;
  assign bus.psram_dqs_in_i = dqs_in_r;
  assign busy_o             = busy_r;
  assign err_o              = err_r;

endmodule
